// File: rtl/key_schedule_ctrl.sv
// Sequential AES key expansion: one 32-bit word per clock into internal storage,
// with indexed 128-bit round-key read and per-round validity.
module key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rk_idx,
  output logic [127:0]     rk_out,
  output logic             rk_valid
);

  localparam int NW = 4*(NR+1);
  localparam int AW = $clog2(NW+1);
  localparam logic [AW-1:0] NK_W   = AW'(NK);
  localparam logic [AW-1:0] LAST_W = AW'(NW-1);
  localparam logic [2:0]    NK_M1  = 3'(NK-1);
  localparam logic [3:0]    NR_I   = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bits [8*(255-b)+7 -: 8], i.e. {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [2:0]    kmod_q, kmod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, wr_en;

  logic [31:0] w_q [NW];
  logic [31:0] prev, sub_in, sub_out, temp, wr_word;
  logic [7:0]  rcon_next;
  logic [3:0]  rk_sel;

  // Single SubWord unit shared by the rotated (kmod==0) and NK=8 kmod==4 cases.
  always_comb begin
    prev    = w_q[wcnt_q - 1'b1];
    sub_in  = (kmod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    temp    = prev;
    if (kmod_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && kmod_q == 3'd4)
      temp = sub_out;
    wr_word   = w_q[wcnt_q - NK_W] ^ temp;
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    kmod_d  = kmod_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = EXPAND;
          wcnt_d  = NK_W;
          kmod_d  = '0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        kmod_d = (kmod_q == NK_M1) ? '0 : kmod_q + 1'b1;
        if (kmod_q == 3'd0)
          rcon_d = rcon_next;
        if (wcnt_q == LAST_W) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      kmod_q  <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      kmod_q  <= kmod_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        for (int unsigned k = 0; k < NK; k++)
          w_q[k] <= key[(NK-1-k)*32 +: 32];
      end else if (wr_en) begin
        w_q[wcnt_q] <= wr_word;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_sel   = (rk_idx <= NR_I) ? rk_idx : '0;
  assign rk_out   = {w_q[AW'({rk_sel, 2'd0})], w_q[AW'({rk_sel, 2'd1})],
                     w_q[AW'({rk_sel, 2'd2})], w_q[AW'({rk_sel, 2'd3})]};
  assign rk_valid = (7'(wcnt_q) >= {5'(rk_idx) + 5'd1, 2'b00}) && (rk_idx <= NR_I);

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: AES-128 and AES-256 instances checked
// against FIPS-197 expansion values, latency, validity and handshake corner cases.
module tb_key_schedule_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start4, busy4, done4, rk_valid4;
  logic [127:0] key4, rk_out4;
  logic [3:0]   rk_idx4;
  logic         start8, busy8, done8, rk_valid8;
  logic [255:0] key8;
  logic [127:0] rk_out8;
  logic [3:0]   rk_idx8;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_Z  = 128'h0;
  localparam logic [255:0] KEY_8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] E_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] E_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  key_schedule_ctrl #(.NK(4), .NR(10)) u4 (
    .clk(clk), .rst(rst), .start(start4), .key(key4), .busy(busy4), .done(done4),
    .rk_idx(rk_idx4), .rk_out(rk_out4), .rk_valid(rk_valid4)
  );

  key_schedule_ctrl #(.NK(8), .NR(14)) u8 (
    .clk(clk), .rst(rst), .start(start8), .key(key8), .busy(busy8), .done(done8),
    .rk_idx(rk_idx8), .rk_out(rk_out8), .rk_valid(rk_valid8)
  );

  // Called at a falling edge; returns at the falling edge right after the start edge.
  task automatic kick4(input logic [127:0] k);
    key4 = k; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; key4 = '1;
  endtask

  task automatic kick8(input logic [255:0] k);
    key8 = k; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; key8 = '1;
  endtask

  task automatic wait_done4(output int lat);
    lat = 0;
    while (done4 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done4: got %b want 0", done4); end
    n_cmp++; if (rk_valid4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid4: got %b want 0", rk_valid4); end
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    n_cmp++; if (rk_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_valid8: got %b want 0", rk_valid8); end
  endtask

  task automatic test_nk4_basic;
    int lat;
    kick4(KEY_A);
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL nk4_busy_rise: got %b want 1", busy4); end
    rk_idx4 = 4'd0; #1;
    n_cmp++; if (rk_valid4 !== 1'b1) begin n_bad++; $display("FAIL nk4_rk0_valid_early: got %b want 1", rk_valid4); end
    n_cmp++; if (rk_out4 !== KEY_A) begin n_bad++; $display("FAIL nk4_rk0: got %h want %h", rk_out4, KEY_A); end
    rk_idx4 = 4'd1; #1;
    n_cmp++; if (rk_valid4 !== 1'b0) begin n_bad++; $display("FAIL nk4_rk1_not_yet: got %b want 0", rk_valid4); end
    wait_done4(lat);
    n_cmp++; if (lat != 40) begin n_bad++; $display("FAIL nk4_latency: got %0d want 40", lat); end
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL nk4_busy_fall: got %b want 0", busy4); end
    @(negedge clk);
    n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL nk4_done_pulse: got %b want 0", done4); end
    rk_idx4 = 4'd1; #1;
    n_cmp++; if (rk_out4 !== A_RK1) begin n_bad++; $display("FAIL nk4_rk1: got %h want %h", rk_out4, A_RK1); end
    n_cmp++; if (rk_valid4 !== 1'b1) begin n_bad++; $display("FAIL nk4_rk1_valid: got %b want 1", rk_valid4); end
    rk_idx4 = 4'd10; #1;
    n_cmp++; if (rk_out4 !== A_RK10) begin n_bad++; $display("FAIL nk4_rk10: got %h want %h", rk_out4, A_RK10); end
    n_cmp++; if (rk_valid4 !== 1'b1) begin n_bad++; $display("FAIL nk4_rk10_valid: got %b want 1", rk_valid4); end
    rk_idx4 = 4'd15; #1;
    n_cmp++; if (rk_valid4 !== 1'b0) begin n_bad++; $display("FAIL nk4_rk15_invalid: got %b want 0", rk_valid4); end
    @(negedge clk);
  endtask

  task automatic test_nk8_basic;
    int lat;
    kick8(KEY_8);
    wait_done8(lat);
    n_cmp++; if (lat != 52) begin n_bad++; $display("FAIL nk8_latency: got %0d want 52", lat); end
    rk_idx8 = 4'd2; #1;
    n_cmp++; if (rk_out8[127:96] !== 32'h9ba35411) begin n_bad++; $display("FAIL nk8_w8: got %h want 9ba35411", rk_out8[127:96]); end
    n_cmp++; if (rk_out8 !== E_RK2) begin n_bad++; $display("FAIL nk8_rk2: got %h want %h", rk_out8, E_RK2); end
    rk_idx8 = 4'd14; #1;
    n_cmp++; if (rk_out8 !== E_RK14) begin n_bad++; $display("FAIL nk8_rk14: got %h want %h", rk_out8, E_RK14); end
    n_cmp++; if (rk_valid8 !== 1'b1) begin n_bad++; $display("FAIL nk8_rk14_valid: got %b want 1", rk_valid8); end
    rk_idx8 = 4'd15; #1;
    n_cmp++; if (rk_valid8 !== 1'b0) begin n_bad++; $display("FAIL nk8_rk15_invalid: got %b want 0", rk_valid8); end
    @(negedge clk);
  endtask

  task automatic test_progressive;
    int n, first;
    rk_idx4 = 4'd2;
    kick4(KEY_A);
    n = 0; first = -1;
    while (n < 100) begin
      if (rk_valid4 === 1'b1 && first < 0) first = n;
      if (done4 === 1'b1) break;
      @(negedge clk); n++;
    end
    n_cmp++; if (first != 8) begin n_bad++; $display("FAIL prog_rk2_first_valid: got %0d want 8", first); end
    n_cmp++; if (n != 40) begin n_bad++; $display("FAIL prog_done_edge: got %0d want 40", n); end
    n_cmp++; if (rk_out4 !== A_RK2) begin n_bad++; $display("FAIL prog_rk2: got %h want %h", rk_out4, A_RK2); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int n, lat, seen11;
    rk_idx4 = 4'd11;
    kick4(KEY_A);
    n = 0; seen11 = 0;
    while (n < 100) begin
      if (rk_valid4 !== 1'b0) seen11++;
      if (n == 4) begin key4 = KEY_B; start4 = 1'b1; end
      if (n == 5) begin start4 = 1'b0; key4 = '1; end
      if (done4 === 1'b1) break;
      @(negedge clk); n++;
    end
    n_cmp++; if (n != 40) begin n_bad++; $display("FAIL busy_ignore_latency: got %0d want 40", n); end
    n_cmp++; if (seen11 != 0) begin n_bad++; $display("FAIL rk11_valid_cycles: got %0d want 0", seen11); end
    rk_idx4 = 4'd10; #1;
    n_cmp++; if (rk_out4 !== A_RK10) begin n_bad++; $display("FAIL busy_ignore_rk10: got %h want %h", rk_out4, A_RK10); end
    kick4(KEY_Z);
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL start_on_done_busy: got %b want 1", busy4); end
    wait_done4(lat);
    n_cmp++; if (lat != 40) begin n_bad++; $display("FAIL start_on_done_latency: got %0d want 40", lat); end
    rk_idx4 = 4'd1; #1;
    n_cmp++; if (rk_out4 !== Z_RK1) begin n_bad++; $display("FAIL zero_rk1: got %h want %h", rk_out4, Z_RK1); end
    rk_idx4 = 4'd10; #1;
    n_cmp++; if (rk_out4 !== Z_RK10) begin n_bad++; $display("FAIL zero_rk10: got %h want %h", rk_out4, Z_RK10); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    rk_idx4 = 4'd0;
    kick4(KEY_A);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy4); end
    n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done4); end
    n_cmp++; if (rk_valid4 !== 1'b0) begin n_bad++; $display("FAIL midrst_rk0_valid: got %b want 0", rk_valid4); end
    @(negedge clk);
    kick4(KEY_A);
    wait_done4(lat);
    n_cmp++; if (lat != 40) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d want 40", lat); end
    rk_idx4 = 4'd1; #1;
    n_cmp++; if (rk_out4 !== A_RK1) begin n_bad++; $display("FAIL midrst_rk1: got %h want %h", rk_out4, A_RK1); end
    rk_idx4 = 4'd10; #1;
    n_cmp++; if (rk_out4 !== A_RK10) begin n_bad++; $display("FAIL midrst_rk10: got %h want %h", rk_out4, A_RK10); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    kick4(KEY_Z);
    wait_done4(lat);
    kick4(KEY_A);
    wait_done4(lat);
    n_cmp++; if (lat != 40) begin n_bad++; $display("FAIL b2b4_latency: got %0d want 40", lat); end
    rk_idx4 = 4'd1; #1;
    n_cmp++; if (rk_out4 !== A_RK1) begin n_bad++; $display("FAIL b2b4_rk1: got %h want %h", rk_out4, A_RK1); end
    rk_idx4 = 4'd10; #1;
    n_cmp++; if (rk_out4 !== A_RK10) begin n_bad++; $display("FAIL b2b4_rk10: got %h want %h", rk_out4, A_RK10); end
    @(negedge clk);
    kick8(KEY_8);
    wait_done8(lat);
    kick8(KEY_8);
    wait_done8(lat);
    n_cmp++; if (lat != 52) begin n_bad++; $display("FAIL b2b8_latency: got %0d want 52", lat); end
    rk_idx8 = 4'd2; #1;
    n_cmp++; if (rk_out8 !== E_RK2) begin n_bad++; $display("FAIL b2b8_rk2: got %h want %h", rk_out8, E_RK2); end
    rk_idx8 = 4'd14; #1;
    n_cmp++; if (rk_out8 !== E_RK14) begin n_bad++; $display("FAIL b2b8_rk14: got %h want %h", rk_out8, E_RK14); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    key4 = '0; key8 = '0;
    rk_idx4 = 4'd0; rk_idx8 = 4'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_nk4_basic;
    test_nk8_basic;
    test_progressive;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- Sequential AES key-schedule engine for the coprocessor. Generates one 32-bit expanded-key word per clock instead of unrolling the whole expansion combinationally.
- Stores all 4*(NR+1) words internally and exposes them to the round datapath as 128-bit round keys through an indexed read port.
- Reports per-round availability, so encryption can start before the expansion completes.
- Start/busy/done handshake toward the coprocessor command controller.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8.
NR, 10, number of rounds; must be NK+6 (10, 12, 14).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new expansion; sampled only when idle
key  in  NK*32  cipher key, word 0 in the most significant 32 bits; sampled on the accepted start edge only
busy  out  1  expansion in progress
done  out  1  one-cycle pulse after the final word is written
rk_idx  in  4  round-key index, 0..NR
rk_out  out  128  round key rk_idx = {w[4i], w[4i+1], w[4i+2], w[4i+3]}, w[4i] in the MSBs
rk_valid  out  1  all four words of round key rk_idx are written for the current key

Behaviour:
- Single synchronous reset, active-high. It has priority over all other inputs.
- Reset values:
  - busy=0, done=0, word counter wcnt=0, state IDLE.
  - rcon=8'h01; phase counter kmod=0.
  - Word storage is not reset.
  - Consequently rk_valid=0.
- State machine: IDLE, EXPAND.
  - IDLE: on an edge with start=1, perform the load step below and enter EXPAND.
  - IDLE: start=0 leaves all state unchanged.
- Load step (same edge that accepts start):
  - w[0..NK-1] <= key; wcnt <= NK; kmod <= 0; rcon <= 8'h01.
  - busy <= 1; done <= 0.
  - Keys from any previous expansion become invalid, because validity derives from wcnt.
- EXPAND step (one word per edge, index i = wcnt):
  - temp = w[i-1].
  - If kmod==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon) (left shift; XOR 8'h1b if bit 7 was set).
  - Else if NK==8 and kmod==4: temp = SubWord(temp).
  - w[i] <= w[i-NK] ^ temp; wcnt <= wcnt+1.
  - kmod <= (kmod==NK-1) ? 0 : kmod+1. No divide or modulo hardware is allowed.
- RotWord is a left byte rotate. SubWord applies the AES forward S-box to each byte.
- Exactly one SubWord instance, i.e. four byte S-boxes, is shared by both SubWord cases.
- Completion:
  - The edge that writes word 4*(NR+1)-1 also sets busy <= 0, done <= 1 and state <= IDLE.
  - done clears on the next edge.
- Latency, counting edges from the accepted start edge (E0) to the edge that raises done: 4*(NR+1)-NK.
  - NK=4: 40.
  - NK=6: 46.
  - NK=8: 52.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle that done is high is accepted, because state is IDLE.
- rk_out is combinational from storage.
- rk_valid = (wcnt >= 4*(rk_idx+1)) and (rk_idx <= NR). rk_out is don't-care when rk_valid=0.
- rk_valid rises progressively during EXPAND. Round key 0 is valid from the cycle after E0 (for NK>=4).
- After done, all round keys stay valid and stable until the next accepted start or reset.
- rk_idx > NR: rk_valid=0.
- Reset mid-expansion: it aborts on that edge (busy=0, done=0, wcnt=0, rk_valid=0). A later start begins cleanly.
- rcon sequence over the run is 01,02,04,08,10,20,40,80,1b,36. It never needs to exceed this for legal NK/NR.

Test Plan:
1. NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy high next cycle; done pulses exactly 40 edges after the start edge.
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
2. NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges.
   - w[8]=9ba35411.
   - rk_idx=14 gives fe4890d1e6188d0b046df344706c631e (exercises the kmod==4 SubWord path).
3. Progressive validity, NK=4: hold rk_idx=2 during expansion -> rk_valid rises on the cycle after the edge writing w[11] (edge E8) and never earlier.
   - rk_idx=11 gives rk_valid=0 at all times.
4. Start while busy: assert start at edge E5 with a different key -> ignored; final keys equal those from the original key.
   - Then assert start the cycle done is high with key 000…0 -> accepted; rk_idx=10 later gives b4ef5bcb3e92e21123e951cf6f8f188e.
5. Reset at edge E20 of an NK=4 run -> busy=0, done=0, rk_valid=0 for rk_idx=0 on the next cycle.
   - A restart with the test 1 key reproduces the test 1 results and latency.
6. Back-to-back runs with different keys -> no stale rcon or kmod carry-over; second run results match FIPS-197 values for its key.
